// File: rtl/cam_capture_if.sv
// Camera byte stream in, assembled RGB pixels and frame status out.
// master = camera/consumer side, slave = cam_capture.
interface cam_capture_if;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic [23:0] rgb_data_out;
   logic        pixel_valid;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        frame_start;
   logic        frame_done;
   logic [7:0]  frame_count;
   logic        line_err;

   modport master (
      output cam_vsync, cam_href, cam_data,
      input  rgb_data_out, pixel_valid, x, y,
      input  frame_start, frame_done, frame_count, line_err
   );

   modport slave (
      input  cam_vsync, cam_href, cam_data,
      output rgb_data_out, pixel_valid, x, y,
      output frame_start, frame_done, frame_count, line_err
   );
endinterface

// File: rtl/cam_capture.sv
// RGB565 camera capture: two bytes per pixel, expanded to 24-bit R,B,G with coordinates.
// Optional CAM_CAPTURE_TEST_PATTERN_EN replaces pixel data with 8 vertical colour bars.
//
// state   | meaning
// SYNC    | after reset, waiting for cam_vsync high
// VBLANK  | vertical blanking, waiting for cam_vsync to fall
// ACTIVE  | inside a frame, no byte pending
// BYTE_HI | high byte latched, waiting for the low byte
module cam_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic         clk,
   input  logic         reset,
   cam_capture_if.slave cam_bus
);

   typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, BYTE_HI} state_t;

   localparam logic [15:0] LP_H = 16'(H_ACTIVE);
   localparam logic [15:0] LP_V = 16'(V_ACTIVE);

   state_t      r_state;
   logic        r_vsync_d;
   logic        r_href_d;
   logic [7:0]  r_hi;
   logic [15:0] r_col;
   logic [15:0] r_row;
   logic        r_line_bytes;
   logic [23:0] r_rgb;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic        r_pixel_valid;
   logic        r_frame_start;
   logic        r_frame_done;
   logic [7:0]  r_frame_count;
   logic        r_line_err;

   logic        w_vsync_rise;
   logic        w_href_fall;
   logic [4:0]  w_r5;
   logic [5:0]  w_g6;
   logic [4:0]  w_b5;
   logic [23:0] w_capture_rgb;
   logic [23:0] w_pixel_rgb;
   logic        w_in_window;

   assign w_vsync_rise = cam_bus.cam_vsync & ~r_vsync_d;
   assign w_href_fall  = ~cam_bus.cam_href & r_href_d;

   assign w_r5 = r_hi[7:3];
   assign w_g6 = {r_hi[2:0], cam_bus.cam_data[7:5]};
   assign w_b5 = cam_bus.cam_data[4:0];
   assign w_capture_rgb = {w_r5, w_r5[4:2], w_b5, w_b5[4:2], w_g6, w_g6[5:4]};

   assign w_in_window = (r_col < LP_H) && (r_row < LP_V);

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
   localparam logic [18:0] LP_H19 = 19'(H_ACTIVE);
   logic [2:0] w_bar;

   assign w_bar = 3'({r_col, 3'b000} / LP_H19);

   // Channels are in R,B,G order, so yellow (R+G) is FF00FF and magenta (R+B) is FFFF00.
   always_comb begin
      w_pixel_rgb = 24'h000000;
      case (w_bar)
         3'd0: w_pixel_rgb = 24'hFFFFFF;
         3'd1: w_pixel_rgb = 24'hFF00FF;
         3'd2: w_pixel_rgb = 24'h00FFFF;
         3'd3: w_pixel_rgb = 24'h0000FF;
         3'd4: w_pixel_rgb = 24'hFFFF00;
         3'd5: w_pixel_rgb = 24'hFF0000;
         3'd6: w_pixel_rgb = 24'h00FF00;
         default: w_pixel_rgb = 24'h000000;
      endcase
   end
`else
   assign w_pixel_rgb = w_capture_rgb;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= SYNC;
         r_vsync_d     <= 1'b0;
         r_href_d      <= 1'b0;
         r_hi          <= 8'h00;
         r_col         <= 16'd0;
         r_row         <= 16'd0;
         r_line_bytes  <= 1'b0;
         r_rgb         <= 24'h000000;
         r_x           <= 10'd0;
         r_y           <= 10'd0;
         r_pixel_valid <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_count <= 8'd0;
         r_line_err    <= 1'b0;
      end else begin
         r_vsync_d     <= cam_bus.cam_vsync;
         r_href_d      <= cam_bus.cam_href;
         r_pixel_valid <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;

         case (r_state)
            SYNC: begin
               if (cam_bus.cam_vsync)
                  r_state <= VBLANK;
            end

            VBLANK: begin
               if (!cam_bus.cam_vsync) begin
                  r_state       <= ACTIVE;
                  r_frame_start <= 1'b1;
                  r_x           <= 10'd0;
                  r_y           <= 10'd0;
                  r_col         <= 16'd0;
                  r_row         <= 16'd0;
                  r_line_bytes  <= 1'b0;
               end
            end

            ACTIVE, BYTE_HI: begin
               if (w_vsync_rise) begin
                  // Only a frame that delivered every line counts as done.
                  if (r_row == LP_V) begin
                     r_frame_done  <= 1'b1;
                     r_frame_count <= r_frame_count + 8'd1;
                  end
                  r_state <= VBLANK;
               end else if (w_href_fall) begin
                  r_col <= 16'd0;
                  if (r_line_bytes && (r_row != 16'hFFFF))
                     r_row <= r_row + 16'd1;
                  if ((r_col != LP_H) || (r_state == BYTE_HI))
                     r_line_err <= 1'b1;
                  r_line_bytes <= 1'b0;
                  r_state      <= ACTIVE;
               end else if (cam_bus.cam_href) begin
                  r_line_bytes <= 1'b1;
                  if (r_state == ACTIVE) begin
                     r_hi    <= cam_bus.cam_data;
                     r_state <= BYTE_HI;
                  end else begin
                     r_state <= ACTIVE;
                     if (w_in_window) begin
                        r_pixel_valid <= 1'b1;
                        r_rgb         <= w_pixel_rgb;
                        r_x           <= r_col[9:0];
                        r_y           <= r_row[9:0];
                     end else begin
                        r_line_err <= 1'b1;
                     end
                     if (r_col != 16'hFFFF)
                        r_col <= r_col + 16'd1;
                  end
               end
            end

            default: r_state <= SYNC;
         endcase
      end
   end

   assign cam_bus.rgb_data_out = r_rgb;
   assign cam_bus.pixel_valid  = r_pixel_valid;
   assign cam_bus.x            = r_x;
   assign cam_bus.y            = r_y;
   assign cam_bus.frame_start  = r_frame_start;
   assign cam_bus.frame_done   = r_frame_done;
   assign cam_bus.frame_count  = r_frame_count;
   assign cam_bus.line_err     = r_line_err;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture; H_ACTIVE=4/V_ACTIVE=2, or H_ACTIVE=8 with CAM_CAPTURE_TEST_PATTERN_EN.
module tb_cam_capture;

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
   localparam int H = 8;
`else
   localparam int H = 4;
`endif
   localparam int V = 2;

   logic clk;
   logic reset;
   cam_capture_if cam_bus ();

   cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk     (clk),
      .reset   (reset),
      .cam_bus (cam_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [43:0] q[$];
   int pv_cycles = 0;
   int fd_cnt    = 0;
   int fs_cnt    = 0;

   // Monitor: records every emitted pixel as {rgb, x, y}.
   always @(posedge clk) begin
      #1;
      if (cam_bus.pixel_valid) begin
         q.push_back({cam_bus.rgb_data_out, cam_bus.x, cam_bus.y});
         pv_cycles++;
      end
      if (cam_bus.frame_done)  fd_cnt++;
      if (cam_bus.frame_start) fs_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      cam_bus.cam_href = 1'b1;
      cam_bus.cam_data = b;
   endtask

   task automatic end_line();
      @(negedge clk);
      cam_bus.cam_href = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic set_vsync(input logic v, input int hold);
      @(negedge clk);
      cam_bus.cam_vsync = v;
      repeat (hold) @(negedge clk);
   endtask

   task automatic send_line(input logic [63:0] bytes, input int n);
      logic [63:0] b;
      b = bytes;
      for (int i = 0; i < n; i++) begin
         send_byte(b[63:56]);
         b = b << 8;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rgb"},   64'(cam_bus.rgb_data_out), 64'h0);
      chk({tag, "_xy"},    64'({cam_bus.x, cam_bus.y}), 64'h0);
      chk({tag, "_fcnt"},  64'(cam_bus.frame_count), 64'h0);
      chk({tag, "_flags"}, 64'({cam_bus.pixel_valid, cam_bus.frame_start,
                                cam_bus.frame_done, cam_bus.line_err}), 64'h0);
   endtask

   function automatic logic [43:0] pix(input logic [23:0] rgb, input int px, input int py);
      return {rgb, 10'(px), 10'(py)};
   endfunction

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                             24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};
`else
   logic [43:0] exp_f1 [8];
   logic [43:0] exp_f2 [7];
`endif

   initial begin
      reset = 1'b1;
      cam_bus.cam_vsync = 1'b0;
      cam_bus.cam_href  = 1'b0;
      cam_bus.cam_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
      set_vsync(1'b1, 3);
      set_vsync(1'b0, 2);
      send_line(64'h1234_5678_9ABC_DEF0, 8);
      send_line(64'h0F1E_2D3C_4B5A_6978, 8);
      end_line();
      chk("pat_count", 64'(q.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("pat_pix%0d", i), 64'(q[i]), 64'(pix(bars[i], i, 0)));
      chk("pat_line_err", 64'(cam_bus.line_err), 64'h0);
`else
      exp_f1 = '{pix(24'hFF0000,0,0), pix(24'h0000FF,1,0), pix(24'h00FF00,2,0), pix(24'h10A545,3,0),
                 pix(24'hFFFFFF,0,1), pix(24'h000000,1,1), pix(24'h848482,2,1), pix(24'h080804,3,1)};
      exp_f2 = '{pix(24'hFF0000,0,0), pix(24'h0000FF,1,0), pix(24'h00FF00,2,0),
                 pix(24'hFFFFFF,0,1), pix(24'h000000,1,1), pix(24'h848482,2,1), pix(24'h080804,3,1)};

      // href while unsynchronised is ignored
      send_line(64'hF800_07E0_0000_0000, 4);
      end_line();
      chk("sync_ignore", 64'(q.size()), 64'd0);

      // Frame 1: first pixel checked cycle by cycle
      set_vsync(1'b1, 3);
      set_vsync(1'b0, 2);
      chk("frame_start1", 64'(fs_cnt), 64'd1);
      send_byte(8'hF8);
      send_byte(8'h00);
      @(negedge clk);
      chk("pv_first", 64'({cam_bus.pixel_valid, cam_bus.rgb_data_out}), 64'h1_FF0000);
      cam_bus.cam_data = 8'h07;
      @(negedge clk);
      chk("pv_one_cycle", 64'(cam_bus.pixel_valid), 64'h0);
      chk("rgb_hold", 64'(cam_bus.rgb_data_out), 64'hFF0000);
      cam_bus.cam_data = 8'hE0;
      send_line(64'h001F_1234_0000_0000, 4);
      end_line();
      send_line(64'hFFFF_0000_8410_0821, 8);
      end_line();
      @(negedge clk);
      cam_bus.cam_vsync = 1'b1;
      @(negedge clk);
      chk("frame_done1", 64'({cam_bus.frame_done, cam_bus.frame_count}), 64'h1_01);
      @(negedge clk);
      chk("frame_done_pulse", 64'(cam_bus.frame_done), 64'h0);
      chk("line_err_clean", 64'(cam_bus.line_err), 64'h0);
      chk("f1_count", 64'(q.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("f1_pix%0d", i), 64'(q[i]), 64'(exp_f1[i]));
      chk("pv_strobes", 64'(pv_cycles), 64'd8);

      // Frame 2: 7-byte line, then a normal line
      set_vsync(1'b0, 2);
      send_line(64'hF800_07E0_001F_AA00, 7);
      chk("err_before_fall", 64'(cam_bus.line_err), 64'h0);
      end_line();
      chk("err_after_fall", 64'(cam_bus.line_err), 64'h1);
      send_line(64'hFFFF_0000_8410_0821, 8);
      end_line();
      set_vsync(1'b1, 3);
      chk("f2_count", 64'(q.size()), 64'd15);
      for (int i = 0; i < 7; i++)
         chk($sformatf("f2_pix%0d", i), 64'(q[8 + i]), 64'(exp_f2[i]));
      chk("f2_done", 64'({8'(fd_cnt), cam_bus.frame_count}), 64'h02_02);
      chk("err_sticky", 64'(cam_bus.line_err), 64'h1);

      // Frame 3 aborted after one line
      set_vsync(1'b0, 2);
      send_line(64'hF800_F800_F800_F800, 8);
      end_line();
      set_vsync(1'b1, 3);
      chk("abort_no_done", 64'({8'(fd_cnt), cam_bus.frame_count}), 64'h02_02);
      chk("abort_pixels", 64'(q.size()), 64'd19);

      // Reset mid-line with a high byte pending
      set_vsync(1'b0, 2);
      send_byte(8'hF8);
      #2 reset = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      @(negedge clk);
      reset = 1'b0;
      send_line(64'h00F8_00F8_00F8_00F8, 8);
      end_line();
      chk("no_pix_after_reset", 64'(q.size()), 64'd19);
      cam_bus.cam_vsync = 1'b1;
      send_line(64'hF800_F800_F800_F800, 8);
      end_line();
      chk("no_pix_in_vblank", 64'(q.size()), 64'd19);
      set_vsync(1'b0, 2);
      send_line(64'h07E0_F800_001F_F800, 8);
      end_line();
      chk("recap_count", 64'(q.size()), 64'd23);
      chk("recap_pix0", 64'(q[19]), 64'(pix(24'h0000FF, 0, 0)));
      chk("recap_pix3", 64'(q[22]), 64'(pix(24'hFF0000, 3, 0)));
      chk("frame_starts", 64'(fs_cnt), 64'd5);
      chk("recap_err", 64'(cam_bus.line_err), 64'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
